mmio_console: RTL and testbench

MMIO_CONSOLE -- requirements
Module: mmio_console

---
 rtl/console_pkg.sv | 29 ++
 rtl/sync_fifo.sv | 63 ++++++
 rtl/mmio_console.sv | 163 ++++++++++++++++
 tb/tb_mmio_console.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/console_pkg.sv
// Shared bus encodings, register offsets and STATUS packing for the MMIO console.
package console_pkg;

  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_RSVD  = 2'b11
  } mem_op_e;

  localparam logic [4:0] OFF_TXDATA = 5'h00;
  localparam logic [4:0] OFF_RXDATA = 5'h08;
  localparam logic [4:0] OFF_STATUS = 5'h10;

  localparam int STATUS_OVF_BIT = 2;
  localparam int STATUS_UDF_BIT = 3;

  function automatic logic [63:0] pack_status(
    input logic       tx_full,
    input logic       rx_empty,
    input logic       ovf,
    input logic       udf,
    input logic [7:0] tx_count,
    input logic [7:0] rx_count
  );
    return {32'b0, rx_count, tx_count, 12'b0, udf, ovf, rx_empty, tx_full};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so pointer overflow wraps modulo DEPTH
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/mmio_console.sv
// Memory-mapped byte console: TXDATA/RXDATA/STATUS registers over TX and RX byte FIFOs.
// The RX path is built only when MMIO_CONSOLE_RX_EN is defined.
module mmio_console
  import console_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = 64'hFFFF_FFFF_FFFF_FF00,
  parameter int          DEPTH     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mem_op,
  input  logic [63:0] mem_addr,
  input  logic [63:0] mem_write_bytes,
  output logic [63:0] mem_data,
  output logic        mem_hit,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_byte,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_byte
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_window;
  logic [4:0]    offset;
  logic          is_rd, is_wr;
  logic          wr_tx, wr_status, rd_rx, rd_status;

  logic          tx_push, tx_pop, tx_full, tx_empty, tx_drop;
  logic [7:0]    tx_dout;
  logic [CW-1:0] tx_count;
  logic [8:0]    tx_cnt9;

  logic          rx_empty, rx_underflow;
  logic [7:0]    rx_head;
  logic [CW-1:0] rx_count;
  logic [8:0]    rx_cnt9;

  logic [63:0]   status_word;
  logic [63:0]   mem_data_q, mem_data_d;
  logic          mem_hit_q, mem_hit_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;

  assign in_window = (mem_addr[63:5] == BASE_ADDR[63:5]);
  assign offset    = mem_addr[4:0];
  assign is_rd     = (mem_op == OP_READ);
  assign is_wr     = (mem_op == OP_WRITE);
  assign wr_tx     = is_wr && in_window && (offset == OFF_TXDATA);
  assign wr_status = is_wr && in_window && (offset == OFF_STATUS);
  assign rd_rx     = is_rd && in_window && (offset == OFF_RXDATA);
  assign rd_status = is_rd && in_window && (offset == OFF_STATUS);

  assign tx_pop   = out_valid && out_ready;
  assign tx_push  = wr_tx;
  assign tx_drop  = wr_tx && tx_full && !tx_pop;

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (mem_write_bytes[7:0]),
    .dout  (tx_dout),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  assign out_valid = !tx_empty;
  assign out_byte  = tx_empty ? 8'h00 : tx_dout;

`ifdef MMIO_CONSOLE_RX_EN
  logic       rx_push, rx_pop, rx_full;
  logic [7:0] rx_dout;
  logic       rdy_q, rdy_d;

  // in_ready is held low for the first cycle after reset release
  assign rdy_d    = 1'b1;
  assign in_ready = rdy_q && !rx_full;
  assign rx_push  = in_valid && in_ready;
  assign rx_pop   = rd_rx && !rx_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rdy_q <= 1'b0;
    else        rdy_q <= rdy_d;
  end

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (in_byte),
    .dout  (rx_dout),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  assign rx_underflow = rd_rx && rx_empty;
  assign rx_head      = rx_empty ? 8'h00 : rx_dout;
`else
  logic unused_rx;

  assign in_ready     = 1'b0;
  assign rx_empty     = 1'b1;
  assign rx_count     = '0;
  assign rx_underflow = 1'b0;
  assign rx_head      = 8'h00;
  assign unused_rx    = ^{in_valid, in_byte};
`endif

  logic unused_misc;
  assign tx_cnt9     = 9'(tx_count);
  assign rx_cnt9     = 9'(rx_count);
  assign unused_misc = ^{mem_write_bytes[63:8], tx_cnt9[8], rx_cnt9[8]};

  assign status_word = pack_status(tx_full, rx_empty, ovf_q, udf_q,
                                   tx_cnt9[7:0], rx_cnt9[7:0]);

  // Flag setting is evaluated after clearing so a same-cycle set wins
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (wr_status && mem_write_bytes[STATUS_OVF_BIT]) ovf_d = 1'b0;
    if (wr_status && mem_write_bytes[STATUS_UDF_BIT]) udf_d = 1'b0;
    if (tx_drop)      ovf_d = 1'b1;
    if (rx_underflow) udf_d = 1'b1;
  end

  always_comb begin
    mem_data_d = 64'b0;
    mem_hit_d  = 1'b0;
    if (rd_status) begin
      mem_hit_d  = 1'b1;
      mem_data_d = status_word;
    end else if (rd_rx) begin
      mem_hit_d  = 1'b1;
      mem_data_d = {56'b0, rx_head};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_data_q <= 64'b0;
      mem_hit_q  <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      mem_data_q <= mem_data_d;
      mem_hit_q  <= mem_hit_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  assign mem_data = mem_data_q;
  assign mem_hit  = mem_hit_q;

endmodule

// File: tb/tb_mmio_console.sv
// Directed self-checking bench for mmio_console; covers the RX path when MMIO_CONSOLE_RX_EN is defined.
module tb_mmio_console;

  localparam logic [63:0] BASE = 64'hFFFF_FFFF_FFFF_FF00;
  localparam logic [63:0] A_TX = BASE + 64'h00;
  localparam logic [63:0] A_RX = BASE + 64'h08;
  localparam logic [63:0] A_ST = BASE + 64'h10;
`ifdef MMIO_CONSOLE_RX_EN
  localparam bit RX_EN = 1'b1;
`else
  localparam bit RX_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  mem_op = 2'b00;
  logic [63:0] mem_addr = 64'b0;
  logic [63:0] mem_write_bytes = 64'b0;
  logic [63:0] mem_data;
  logic        mem_hit;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_byte;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_byte = 8'h00;

  int checks = 0;
  int errors = 0;

  mmio_console #(.BASE_ADDR(BASE), .DEPTH(16)) dut (
    .clk             (clk),
    .reset           (rst_n),
    .mem_op          (mem_op),
    .mem_addr        (mem_addr),
    .mem_write_bytes (mem_write_bytes),
    .mem_data        (mem_data),
    .mem_hit         (mem_hit),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_byte        (out_byte),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_byte         (in_byte)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic bus_write(input logic [63:0] addr, input logic [63:0] data);
    @(negedge clk);
    mem_op = 2'b10;
    mem_addr = addr;
    mem_write_bytes = data;
    @(negedge clk);
    mem_op = 2'b00;
    mem_write_bytes = 64'b0;
  endtask

  task automatic bus_read(input logic [63:0] addr, output logic [63:0] d, output logic h);
    @(negedge clk);
    mem_op = 2'b01;
    mem_addr = addr;
    @(negedge clk);
    d = mem_data;
    h = mem_hit;
    mem_op = 2'b00;
  endtask

  task automatic test_reset;
    logic [63:0] d;
    logic h;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (mem_data !== 64'b0) begin errors++; $display("[TB] FAIL reset_mem_data: got %h expected 0", mem_data); end
    checks++; if (mem_hit !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_hit: got %b expected 0", mem_hit); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_byte !== 8'h00) begin errors++; $display("[TB] FAIL reset_out_byte: got %h expected 0", out_byte); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready); end
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL release_in_ready_early: got %b expected 0", in_ready); end
    @(negedge clk);
    checks++; if (in_ready !== RX_EN) begin errors++; $display("[TB] FAIL release_in_ready: got %b expected %b", in_ready, RX_EN); end
    bus_read(A_ST, d, h);
    checks++; if (h !== 1'b1 || d !== 64'h2) begin errors++; $display("[TB] FAIL reset_status: got hit=%b data=%h expected hit=1 data=2", h, d); end
  endtask

  task automatic test_tx_stream;
    bus_write(A_TX, 64'h41);
    bus_write(A_TX, 64'h42);
    checks++; if (out_valid !== 1'b1 || out_byte !== 8'h41) begin errors++; $display("[TB] FAIL tx_first: got v=%b b=%h expected v=1 b=41", out_valid, out_byte); end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_byte !== 8'h42) begin errors++; $display("[TB] FAIL tx_second: got v=%b b=%h expected v=1 b=42", out_valid, out_byte); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || out_byte !== 8'h00) begin errors++; $display("[TB] FAIL tx_drained: got v=%b b=%h expected v=0 b=00", out_valid, out_byte); end
    out_ready = 1'b0;
  endtask

  task automatic test_tx_overflow;
    logic [63:0] d;
    logic h;
    for (int i = 0; i < 17; i++) bus_write(A_TX, 64'(16 + i));
    checks++; if (out_byte !== 8'h10) begin errors++; $display("[TB] FAIL ovf_head: got %h expected 10", out_byte); end
    bus_read(A_ST, d, h);
    checks++; if (d !== 64'h0010_0007) begin errors++; $display("[TB] FAIL ovf_status: got %h expected 0000000000100007", d); end
    bus_write(A_ST, 64'h4);
    bus_read(A_ST, d, h);
    checks++; if (d !== 64'h0010_0003) begin errors++; $display("[TB] FAIL ovf_clear: got %h expected 0000000000100003", d); end
  endtask

  task automatic test_full_handshake;
    logic [63:0] d;
    logic [7:0] exp_b;
    logic h;
    @(negedge clk);
    out_ready = 1'b1;
    mem_op = 2'b10;
    mem_addr = A_TX;
    mem_write_bytes = 64'h99;
    @(negedge clk);
    out_ready = 1'b0;
    mem_op = 2'b00;
    mem_write_bytes = 64'b0;
    bus_read(A_ST, d, h);
    checks++; if (d !== 64'h0010_0003) begin errors++; $display("[TB] FAIL full_push_status: got %h expected 0000000000100003", d); end
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_b = (i < 15) ? 8'(17 + i) : 8'h99;
      checks++; if (out_valid !== 1'b1 || out_byte !== exp_b) begin errors++; $display("[TB] FAIL drain_%0d: got v=%b b=%h expected v=1 b=%h", i, out_valid, out_byte, exp_b); end
      @(negedge clk);
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_empty: got %b expected 0", out_valid); end
    out_ready = 1'b0;
  endtask

`ifdef MMIO_CONSOLE_RX_EN
  task automatic test_rx;
    logic [63:0] d;
    logic h;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rx_ready: got %b expected 1", in_ready); end
    in_valid = 1'b1;
    in_byte = 8'h5A;
    @(negedge clk);
    in_valid = 1'b0;
    bus_read(A_RX, d, h);
    checks++; if (h !== 1'b1 || d !== 64'h5A) begin errors++; $display("[TB] FAIL rx_read: got hit=%b data=%h expected hit=1 data=5a", h, d); end
    bus_read(A_RX, d, h);
    checks++; if (h !== 1'b1 || d !== 64'h0) begin errors++; $display("[TB] FAIL rx_empty_read: got hit=%b data=%h expected hit=1 data=0", h, d); end
    bus_read(A_ST, d, h);
    checks++; if (d !== 64'hA) begin errors++; $display("[TB] FAIL udf_status: got %h expected a", d); end
    bus_write(A_ST, 64'h8);
    bus_read(A_ST, d, h);
    checks++; if (d !== 64'h2) begin errors++; $display("[TB] FAIL udf_clear: got %h expected 2", d); end
    @(negedge clk);
    in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_byte = 8'(96 + i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL rx_full_ready: got %b expected 0", in_ready); end
    bus_read(A_ST, d, h);
    checks++; if (d !== 64'h1000_0000) begin errors++; $display("[TB] FAIL rx_full_status: got %h expected 10000000", d); end
    for (int i = 0; i < 16; i++) begin
      bus_read(A_RX, d, h);
      checks++; if (d !== 64'(96 + i)) begin errors++; $display("[TB] FAIL rx_drain_%0d: got %h expected %h", i, d, 64'(96 + i)); end
    end
  endtask
`else
  task automatic test_rx;
    logic [63:0] d;
    logic h;
    @(negedge clk);
    in_valid = 1'b1;
    in_byte = 8'h5A;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL rx_off_ready: got %b expected 0", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    bus_read(A_RX, d, h);
    checks++; if (h !== 1'b1 || d !== 64'h0) begin errors++; $display("[TB] FAIL rx_off_read: got hit=%b data=%h expected hit=1 data=0", h, d); end
    bus_read(A_ST, d, h);
    checks++; if (d !== 64'h2) begin errors++; $display("[TB] FAIL rx_off_status: got %h expected 2", d); end
  endtask
`endif

  task automatic test_decode;
    logic [63:0] d;
    logic h;
    bus_read(BASE - 64'h8, d, h);
    checks++; if (h !== 1'b0 || d !== 64'h0) begin errors++; $display("[TB] FAIL below_window: got hit=%b data=%h expected hit=0 data=0", h, d); end
    bus_read(BASE + 64'h18, d, h);
    checks++; if (h !== 1'b0 || d !== 64'h0) begin errors++; $display("[TB] FAIL offset_18: got hit=%b data=%h expected hit=0 data=0", h, d); end
    @(negedge clk);
    mem_op = 2'b11;
    mem_addr = A_ST;
    @(negedge clk);
    checks++; if (mem_hit !== 1'b0) begin errors++; $display("[TB] FAIL reserved_op: got %b expected 0", mem_hit); end
    mem_op = 2'b00;
    bus_write(BASE + 64'h18, 64'h41);
    bus_write(BASE - 64'h8, 64'h41);
    bus_write(BASE - 64'h20, 64'h41);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stray_write_tx: got %b expected 0", out_valid); end
    bus_read(A_ST, d, h);
    checks++; if (d !== 64'h2) begin errors++; $display("[TB] FAIL stray_status: got %h expected 2", d); end
  endtask

  task automatic test_reset_midop;
    logic [63:0] d;
    logic h;
    if (RX_EN) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_byte = 8'h33;
      repeat (2) @(negedge clk);
      in_valid = 1'b0;
    end
    for (int i = 0; i < 3; i++) bus_write(A_TX, 64'(80 + i));
    @(negedge clk);
    mem_op = 2'b01;
    mem_addr = A_ST;
    @(posedge clk);
    #1;
    checks++; if (mem_hit !== 1'b1) begin errors++; $display("[TB] FAIL pending_hit: got %b expected 1", mem_hit); end
    rst_n = 1'b0;
    #1;
    checks++; if (mem_hit !== 1'b0 || mem_data !== 64'b0) begin errors++; $display("[TB] FAIL midop_bus: got hit=%b data=%h expected hit=0 data=0", mem_hit, mem_data); end
    checks++; if (out_valid !== 1'b0 || out_byte !== 8'h00 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL midop_streams: got v=%b b=%h r=%b expected 0 0 0", out_valid, out_byte, in_ready); end
    @(negedge clk);
    mem_op = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    bus_read(A_ST, d, h);
    checks++; if (d !== 64'h2) begin errors++; $display("[TB] FAIL midop_status: got %h expected 2", d); end
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset;
    test_tx_stream;
    test_tx_overflow;
    test_full_handshake;
    test_rx;
    test_decode;
    test_reset_midop;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
